// File: rtl/mem_sequencer_pkg.sv
// mem_sequencer_pkg: shared types and constants for the 6502 memory-access sequencer.
// VEC_LO/VEC_HI exist only when RESET_VECTOR_EN is defined.
package mem_sequencer_pkg;
    typedef enum logic [2:0] {
        FETCH_OP, DECODE, FETCH_LO, FETCH_HI, DATA_RD, DATA_WR
`ifdef RESET_VECTOR_EN
        , VEC_LO, VEC_HI
`endif
    } seq_state_t;
    typedef enum logic [1:0] {NONE, READ, WRITE} acc_t;
    localparam logic [15:0] VEC_ADDR_DFLT = 16'hFFFC;
endpackage

// File: rtl/mem_sequencer_pc_reg.sv
// pc_reg: program counter with byte-slice loads (low/high) and wrapping increment.
module pc_reg #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_i,
    input  logic              ld_lo_i,
    input  logic              ld_hi_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [ADDR_W-1:0] pc_o
);
    localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'({DATA_W{1'b1}});
    localparam logic [ADDR_W-1:0] HI_MASK = LO_MASK << DATA_W;
    logic [ADDR_W-1:0] pc_q, pc_d, din_ext;
    always_comb begin
        din_ext = ADDR_W'(din_i);
        pc_d = ld_lo_i ? (pc_q & ~LO_MASK) | din_ext :
               ld_hi_i ? (pc_q & ~HI_MASK) | (din_ext << DATA_W) :
               inc_i   ? pc_q + ADDR_W'(1) : pc_q;
    end
    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else pc_q <= pc_d;
    end
    assign pc_o = pc_q;
endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: per-instruction opcode / operand / data access sequencer for the 6502 core.
// Define RESET_VECTOR_EN to load the PC from VEC_ADDR/VEC_ADDR+1 after reset.
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] VEC_ADDR = ADDR_W'(VEC_ADDR_DFLT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] opcode,
    input  logic [1:0]        op_len,
    input  acc_t              acc,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ea,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              inst_done,
    output logic [ADDR_W-1:0] pc
);
    localparam logic [ADDR_W-1:0] HI_MASK = ADDR_W'({DATA_W{1'b1}}) << DATA_W;
    seq_state_t        state_q, state_d, data_st;
    acc_t              acc_q, acc_d;
    logic              two_q, two_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [DATA_W-1:0] opcode_q, opcode_d, rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d, inst_done_q, inst_done_d;
    logic              vec_lo, vec_hi, pc_inc;

`ifdef RESET_VECTOR_EN
    localparam seq_state_t RST_ST = VEC_LO;
    assign vec_lo = state_q == VEC_LO;
    assign vec_hi = state_q == VEC_HI;
`else
    localparam seq_state_t RST_ST = FETCH_OP;
    assign vec_lo = 1'b0;
    assign vec_hi = 1'b0;
`endif

    assign pc_inc = mem_ready && (state_q inside {FETCH_OP, FETCH_LO, FETCH_HI});

    pc_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (pc_inc),
        .ld_lo_i(mem_ready && vec_lo),
        .ld_hi_i(mem_ready && vec_hi),
        .din_i  (mem_rdata),
        .pc_o   (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RST_ST;
            acc_q       <= NONE;
            two_q       <= 1'b0;
            ea_q        <= '0;
            opcode_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            inst_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            two_q       <= two_d;
            ea_q        <= ea_d;
            opcode_q    <= opcode_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            inst_done_q <= inst_done_d;
        end
    end

    // acc is live in DECODE; later states use the copy latched there
    always_comb begin
        acc_d   = state_q == DECODE ? acc : acc_q;
        data_st = acc_d == READ ? DATA_RD : acc_d == WRITE ? DATA_WR : FETCH_OP;
        state_d = state_q;
        case (state_q)
            FETCH_OP: if (mem_ready) state_d = DECODE;
            DECODE:   state_d = op_len != 2'd0 ? FETCH_LO : data_st;
            FETCH_LO: if (mem_ready) state_d = two_q ? FETCH_HI : data_st;
            FETCH_HI: if (mem_ready) state_d = data_st;
            DATA_RD:  if (mem_ready) state_d = FETCH_OP;
            DATA_WR:  if (mem_ready) state_d = FETCH_OP;
`ifdef RESET_VECTOR_EN
            VEC_LO:   if (mem_ready) state_d = VEC_HI;
            VEC_HI:   if (mem_ready) state_d = FETCH_OP;
`endif
            default:  state_d = FETCH_OP;
        endcase
    end

    always_comb begin
        two_d       = state_q == DECODE ? op_len[1] : two_q;
        opcode_d    = state_q == FETCH_OP && mem_ready ? mem_rdata : opcode_q;
        ea_d        = !mem_ready ? ea_q :
                      state_q == FETCH_LO ? ADDR_W'(mem_rdata) :
                      state_q == FETCH_HI ? (ea_q & ~HI_MASK) | (ADDR_W'(mem_rdata) << DATA_W) : ea_q;
        rd_valid_d  = state_q == DATA_RD && mem_ready;
        rd_data_d   = rd_valid_d ? mem_rdata : rd_data_q;
        inst_done_d = state_d == FETCH_OP && state_q != FETCH_OP && !vec_hi;
        mem_addr    = state_q inside {DATA_RD, DATA_WR} ? ea_q :
                      vec_lo || vec_hi ? VEC_ADDR + ADDR_W'(vec_hi) : pc;
        mem_we      = state_q == DATA_WR && !reset;
        mem_wdata   = wr_data;
    end

    assign opcode    = opcode_q;
    assign ea        = ea_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign inst_done = inst_done_q;
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: scoreboard bench running a short 6502 program through mem_sequencer.
// Program starts at FFF8 so the FFFF->0000 PC wrap is exercised on the way.
module tb_mem_sequencer;
    import mem_sequencer_pkg::*;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] pc;
        logic [15:0] ea;
        logic [7:0]  op;
        bit          rd;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, mem_ready = 1'b1;
    logic [7:0]  mem_rdata, mem_wdata, opcode, rd_data;
    logic [7:0]  wr_data = 8'hC3;
    logic [15:0] mem_addr, ea, pc;
    logic        mem_we, rd_valid, inst_done;
    logic [1:0]  op_len;
    acc_t        acc;
    logic [7:0]  mem [0:65535];
    int          n_cmp = 0, n_bad = 0;
    exp_t        sbq[$];
    exp_t        e;

    always #5 clk = ~clk;

    mem_sequencer #(.RESET_PC(16'hFFF8)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .opcode   (opcode),
        .op_len   (op_len),
        .acc      (acc),
        .wr_data  (wr_data),
        .ea       (ea),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .inst_done(inst_done),
        .pc       (pc)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we && mem_ready) mem[mem_addr] <= mem_wdata;

    // tiny decoder standing in for control; AE uses op_len 3 (treated as 2)
    always_comb begin
        op_len = 2'd0;
        acc    = NONE;
        case (opcode)
            8'h85: begin op_len = 2'd1; acc = WRITE; end
            8'hA5: begin op_len = 2'd1; acc = READ;  end
            8'hAD: begin op_len = 2'd2; acc = READ;  end
            8'hAE: begin op_len = 2'd3; acc = READ;  end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t done_e(logic [15:0] p, logic [15:0] a, logic [7:0] o, bit r, logic [7:0] d);
        exp_t x;
        x = '{wr: 1'b0, addr: 16'h0, data: d, pc: p, ea: a, op: o, rd: r};
        return x;
    endfunction

    function automatic exp_t wr_e(logic [15:0] a, logic [7:0] d);
        exp_t x;
        x = '{wr: 1'b1, addr: a, data: d, pc: 16'h0, ea: 16'h0, op: 8'h0, rd: 1'b0};
        return x;
    endfunction

    always @(negedge clk) begin
        if (!reset && mem_we && mem_ready) begin
            if (sbq.size() == 0 || !sbq[0].wr) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", {8'h0, mem_wdata}, {8'h0, e.data});
            end
        end
        if (!reset && inst_done) begin
            if (sbq.size() == 0 || sbq[0].wr) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: got inst_done at pc %h, required a write or nothing", pc);
            end else begin
                e = sbq.pop_front();
                chk("done_pc", pc, e.pc);
                chk("done_ea", ea, e.ea);
                chk("done_opcode", {8'h0, opcode}, {8'h0, e.op});
                chk("done_rd_valid", {15'h0, rd_valid}, {15'h0, e.rd});
                if (e.rd) chk("done_rd_data", {8'h0, rd_data}, {8'h0, e.data});
            end
        end
        if (!reset && rd_valid && !inst_done) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_valid_alone: got rd_valid=1 inst_done=0, required both together");
        end
    end

    initial begin
        logic found;
        for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
        mem[16'hFFF8] <= 8'hEA;
        mem[16'hFFF9] <= 8'h85; mem[16'hFFFA] <= 8'h80;
        mem[16'hFFFB] <= 8'hAD; mem[16'hFFFC] <= 8'h34; mem[16'hFFFD] <= 8'h12;
        mem[16'hFFFE] <= 8'hEA;
        mem[16'hFFFF] <= 8'hA5; mem[16'h0000] <= 8'h40;
        mem[16'h0001] <= 8'hAE; mem[16'h0002] <= 8'h35; mem[16'h0003] <= 8'h12;
        mem[16'h0004] <= 8'h85; mem[16'h0005] <= 8'h90;
        mem[16'h1234] <= 8'h5A; mem[16'h1235] <= 8'h99; mem[16'h0040] <= 8'h77;
        sbq.push_back(done_e(16'hFFF9, 16'h0000, 8'hEA, 1'b0, 8'h00));
        sbq.push_back(wr_e(16'h0080, 8'hC3));
        sbq.push_back(done_e(16'hFFFB, 16'h0080, 8'h85, 1'b0, 8'h00));
        sbq.push_back(done_e(16'hFFFE, 16'h1234, 8'hAD, 1'b1, 8'h5A));
        sbq.push_back(done_e(16'hFFFF, 16'h1234, 8'hEA, 1'b0, 8'h00));
        sbq.push_back(done_e(16'h0001, 16'h0040, 8'hA5, 1'b1, 8'h77));
        sbq.push_back(done_e(16'h0004, 16'h1235, 8'hAE, 1'b1, 8'h99));
        repeat (2) @(negedge clk);
        chk("rst_we", {15'h0, mem_we}, 16'h0);
        chk("rst_addr", mem_addr, 16'hFFF8);
        chk("rst_pc", pc, 16'hFFF8);
        chk("rst_ea", ea, 16'h0000);
        chk("rst_done", {15'h0, inst_done}, 16'h0);
        reset = 1'b0;
        for (int c = 0; c < 200 && mem_addr !== 16'h0003; c++) @(negedge clk);
        chk("stall_reach", mem_addr, 16'h0003);
        mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_addr", mem_addr, 16'h0003);
            chk("stall_pc", pc, 16'h0003);
        end
        mem_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk);
            #1 found = mem_we && mem_addr == 16'h0090;
        end
        chk("abort_reach", {15'h0, found}, 16'h1);
        reset = 1'b1;
        sbq.push_back(done_e(16'hFFF9, 16'h0000, 8'hEA, 1'b0, 8'h00));
        @(negedge clk);
        chk("abort_we", {15'h0, mem_we}, 16'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_addr", mem_addr, 16'hFFF8);
        chk("post_rst_pc", pc, 16'hFFF8);
        chk("post_rst_opcode", {8'h0, opcode}, 16'h0);
        chk("post_rst_rd_data", {8'h0, rd_data}, 16'h0);
        chk("post_rst_rd_valid", {15'h0, rd_valid}, 16'h0);
        for (int c = 0; c < 100 && sbq.size() != 0; c++) @(negedge clk);
        chk("queue_drained", 16'(sbq.size()), 16'h0);
        chk("mem_0080", {8'h0, mem[16'h0080]}, 16'h00C3);
        chk("mem_0090", {8'h0, mem[16'h0090]}, 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL timeout: got no completion, required finish within 100000 time units");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
